// File: rtl/sort_stage_hs.sv
// sort_stage_hs: two-stage valid/ready sort stage that extracts the max word (min when SORT_STAGE_MIN_MODE_EN) and forwards the residual set
module sort_stage_hs #(
  parameter int M = 8,
  parameter int N = 16,
  localparam int IDX_W = $clog2(M)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [M-1:0][N-1:0] i_chi,
  input  logic [M-1:0]        i_mask,
`ifdef SORT_STAGE_MIN_MODE_EN
  input  logic                i_min_mode,
`endif
  output logic                o_valid,
  input  logic                i_ready,
  output logic [M-1:0][N-1:0] o_chi,
  output logic [M-1:0]        o_mask,
  output logic [N-1:0]        o_y_q,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_hit
);
  logic                s1_v;
  logic [M-1:0][N-1:0] s1_chi;
  logic [M-1:0]        s1_mask;
  logic [M-1:0]        s1_h;
  logic [M-1:0]        h_d;
  logic                mm;
  logic                ld1;
  logic                ld2;
  logic [M-1:0][N-1:0] chi_d;
  logic [N-1:0]        y_d;
  logic [IDX_W-1:0]    idx_d;
`ifdef SORT_STAGE_MIN_MODE_EN
  assign mm = i_min_mode;
`else
  assign mm = 1'b0;
`endif
  assign ld2     = ~o_valid | i_ready;
  assign ld1     = ~s1_v | ld2;
  assign o_ready = ld1;
  // word i wins only if it beats every other participating word; ties go to the lower index
  always_comb begin
    h_d = '0;
    for (int i = 0; i < M; i++) begin
      h_d[i] = i_mask[i];
      for (int j = 0; j < M; j++)
        if (j != i && i_mask[j])
          h_d[i] = h_d[i] & ((mm ? (i_chi[i] < i_chi[j]) : (i_chi[i] > i_chi[j])) | (i_chi[i] == i_chi[j] && i < j));
    end
  end
  always_comb begin
    y_d   = '0;
    idx_d = '0;
    chi_d = '0;
    for (int i = 0; i < M; i++) begin
      y_d      = y_d | (s1_h[i] ? s1_chi[i] : '0);
      idx_d    = idx_d | (s1_h[i] ? IDX_W'(i) : '0);
      chi_d[i] = s1_h[i] ? '0 : s1_chi[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v    <= 1'b0;
      s1_chi  <= '0;
      s1_mask <= '0;
      s1_h    <= '0;
    end else if (ld1) begin
      s1_v <= i_valid;
      if (i_valid) begin
        s1_chi  <= i_chi;
        s1_mask <= i_mask;
        s1_h    <= h_d;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_valid <= 1'b0;
      o_chi   <= '0;
      o_mask  <= '0;
      o_y_q   <= '0;
      o_idx   <= '0;
      o_hit   <= 1'b0;
    end else if (ld2) begin
      o_valid <= s1_v;
      if (s1_v) begin
        o_chi  <= chi_d;
        o_mask <= s1_mask & ~s1_h;
        o_y_q  <= y_d;
        o_idx  <= idx_d;
        o_hit  <= |s1_h;
      end
    end
endmodule

// File: doc/sort_stage_hs.md
Name: sort_stage_hs

Overview:
- Parametrised next-generation sort stage with a valid/ready handshake on both sides.
- Takes a set of M words of N bits plus a per-word valid mask.
- Extracts the extreme word: maximum by default, minimum optionally.
- Outputs the extracted value and its index, and forwards the residual set (winner cleared, mask bit dropped) so stages can be chained into a full selection sorter.
- Two-stage pipeline: comparison-matrix stage, then extraction stage; both stalls cleanly under backpressure.

Parameters:
- M, 8: number of words per set; legal range 2..64.
- N, 16: word width in bits; legal range 1..64.
- IDX_W, $clog2(M): index width. Derived; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- i_valid  in  1  input set valid.
- o_ready  out  1  stage can accept input this cycle.
- i_chi  in  [M-1:0][N-1:0]  input words.
- i_mask  in  [M-1:0]  per-word valid, 1 = word participates.
- o_valid  out  1  output set valid.
- i_ready  in  1  downstream accepts output.
- o_chi  out  [M-1:0][N-1:0]  residual words; winner zeroed.
- o_mask  out  [M-1:0]  residual mask; winner bit cleared.
- o_y_q  out  N  extracted value.
- o_idx  out  IDX_W  index of extracted word.
- o_hit  out  1  1 = a word was extracted; 0 = input mask was empty.

Behaviour:
- Reset (async, rst=1): every output register and o_valid = 0; o_ready = 1 after reset release; all internal valid flags = 0.
- Stage 1 (light):
  - On accept (i_valid & o_ready), register i_chi and i_mask.
  - Register h[M-1:0], where h[i] = mask[i] AND, for every j != i with mask[j]=1, (chi[i] > chi[j]) or (chi[i] == chi[j] and i < j).
  - Ties go to the lowest index, so h is one-hot or all-zero.
- Stage 2 (dark): registers the following from the stage-1 registers.
  - o_y_q = OR over i of (h[i] ? chi[i] : 0).
  - o_idx = one-hot-to-binary of h.
  - o_hit = |h.
  - o_chi[i] = h[i] ? 0 : chi[i].
  - o_mask = mask & ~h.
- Latency: exactly 2 cycles from accept to o_valid when i_ready is held 1. Throughput is 1 set/cycle.
- Handshake:
  - Stage 2 loads when it is empty or (o_valid & i_ready).
  - Stage 1 loads when it is empty or stage 2 loads.
  - o_ready = stage-1 empty OR stage 2 loads. Combinational from i_ready; no other combinational input-to-output path.
  - Output data is held stable while o_valid=1 and i_ready=0.
  - i_chi/i_mask are ignored when not accepted.
- Simultaneous accept and drain in the same cycle: both happen; no bubble inserted.
- Empty mask: o_hit=0, o_y_q=0, o_idx=0, o_chi = input chi unchanged, o_mask=0. Still produces a valid output beat.
- Mask bit 0 with nonzero data: word never wins; it passes through unchanged in o_chi.
- Reset mid-operation: in-flight sets are discarded; no partial beat emitted.
- Full pipeline with i_ready=0: holds 2 sets; o_ready=0 until i_ready rises.

Optional Feature:
- SORT_STAGE_MIN_MODE_EN defined:
  - Adds input port i_min_mode (1 bit), sampled with each accepted set and carried through stage 1.
  - When 1, the comparison becomes (chi[i] < chi[j]) or (equal and i < j), so the minimum is extracted.
- Not defined: port absent; always maximum.

Test Plan:
- M=8,N=16, chi={7:0x0010,6:0x0300,5:0x0005,4:0x0300,3:0,2:0xFFFF,1:1,0:2}, mask=0xFB -> o_y_q=0x0300, o_idx=4, o_hit=1, o_mask=0xEB, o_chi[4]=0, o_chi[2]=0xFFFF; o_valid 2 cycles after accept.
- All words 0x00AA, mask=0xFF -> o_idx=0 (lowest-index tie), o_mask=0xFE; chain 8 stages -> o_idx sequence 0..7, final mask 0x00.
- mask=0x00 -> o_hit=0, o_y_q=0, o_idx=0, o_chi equals input, o_valid still asserted.
- Back-to-back 4 sets with i_ready=0 from cycle 2 -> o_ready drops after 2 accepts. Output held stable for 10 cycles. Raise i_ready -> 4 results drain in order, one per cycle.
- Assert rst for 1 cycle while 2 sets are in flight -> o_valid=0 immediately, all outputs 0, no stale beat after release.
- With SORT_STAGE_MIN_MODE_EN, i_min_mode=1, chi={3:9,2:4,1:4,0:12}, mask=0xF -> o_y_q=4, o_idx=1, o_mask=0xD.
